// File: rtl/touch_zone_if.sv
// -----------------------------------------------------------------------------
// touch_zone_if
// Bundles the touch-sample, zone-configuration and event signals of the
// touch_zone_decoder.
//   master : drives samples/config, observes zone state and event pulses
//   slave  : the decoder itself
// Signals:
//   smp_valid, tor_x, tor_y          touch sample strobe and coordinates
//   cfg_we, cfg_idx, cfg_x1..cfg_y2  zone rectangle write port (inclusive bounds)
//   zone_hit, any_hit, act_zone      debounced pressed state
//   press_p, release_p, repeat_p     one-cycle event pulses per zone
// -----------------------------------------------------------------------------
interface touch_zone_if #(
  parameter int NZONES = 4,
  parameter int XW     = 10,
  parameter int YW     = 9
);
  logic              smp_valid;
  logic [XW-1:0]     tor_x;
  logic [YW-1:0]     tor_y;
  logic              cfg_we;
  logic [2:0]        cfg_idx;
  logic [XW-1:0]     cfg_x1;
  logic [XW-1:0]     cfg_x2;
  logic [YW-1:0]     cfg_y1;
  logic [YW-1:0]     cfg_y2;
  logic [NZONES-1:0] zone_hit;
  logic              any_hit;
  logic [2:0]        act_zone;
  logic [NZONES-1:0] press_p;
  logic [NZONES-1:0] release_p;
  logic [NZONES-1:0] repeat_p;

  modport master (
    output smp_valid, tor_x, tor_y, cfg_we, cfg_idx, cfg_x1, cfg_x2, cfg_y1, cfg_y2,
    input  zone_hit, any_hit, act_zone, press_p, release_p, repeat_p
  );

  modport slave (
    input  smp_valid, tor_x, tor_y, cfg_we, cfg_idx, cfg_x1, cfg_x2, cfg_y1, cfg_y2,
    output zone_hit, any_hit, act_zone, press_p, release_p, repeat_p
  );
endinterface

// File: rtl/touch_zone_decoder.sv
// -----------------------------------------------------------------------------
// touch_zone_decoder
// Maps touch samples onto up to 8 rectangular zones, debounces each zone
// with an IDLE/PRESSED state machine and emits press/release (and optionally
// repeat) pulses.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    touch_zone_if.slave (samples, zone config, state and pulses)
// Optional feature:
//   TOUCH_REPEAT_EN  when defined, a held zone pulses repeat_p every RPT
//                    samples; otherwise repeat_p is tied low.
// -----------------------------------------------------------------------------
module touch_zone_decoder #(
  parameter int NZONES = 4,
  parameter int XW     = 10,
  parameter int YW     = 9,
  parameter int DEB    = 3,
  parameter int RPT    = 32
) (
  input logic         clk,
  input logic         reset,
  touch_zone_if.slave bus
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESSED = 1'b1;
  localparam logic [3:0] DEB_CNT    = 4'(DEB);

  logic [NZONES-1:0][XW-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [NZONES-1:0][YW-1:0] y1_q, y1_d, y2_q, y2_d;
  logic [NZONES-1:0]         state_q, state_d;
  logic [NZONES-1:0][3:0]    cnt_q, cnt_d;
  logic [NZONES-1:0]         inside_s;
  logic [NZONES-1:0]         press_q, press_d;
  logic [NZONES-1:0]         release_q, release_d;
  logic                      any_q, any_d;
  logic [2:0]                act_q, act_d;

`ifdef TOUCH_REPEAT_EN
  localparam int             RW      = (RPT < 2) ? 1 : $clog2(RPT + 1);
  localparam logic [RW-1:0]  RPT_CNT = RW'(RPT);
  logic [NZONES-1:0][RW-1:0] rpt_q, rpt_d;
  logic [NZONES-1:0]         repeat_q, repeat_d;
`endif

  // 4-bit saturating increment for the debounce counters
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  // Raw hit test; an inverted rectangle (x1>x2 or y1>y2) never matches
  for (genvar g = 0; g < NZONES; g++) begin : g_inside
    assign inside_s[g] = (x1_q[g] <= x2_q[g]) && (y1_q[g] <= y2_q[g]) &&
                         (bus.tor_x >= x1_q[g]) && (bus.tor_x <= x2_q[g]) &&
                         (bus.tor_y >= y1_q[g]) && (bus.tor_y <= y2_q[g]);
  end

  // Per-zone next state: config write beats a sample; no sample freezes the zone
  always_comb begin
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = '0;
    release_d = '0;
`ifdef TOUCH_REPEAT_EN
    rpt_d     = rpt_q;
    repeat_d  = '0;
`endif
    for (int i = 0; i < NZONES; i++) begin
      if (bus.cfg_we && (bus.cfg_idx == 3'(i))) begin
        // Silent return to IDLE: a reprogrammed zone never reports a release
        x1_d[i]    = bus.cfg_x1;
        x2_d[i]    = bus.cfg_x2;
        y1_d[i]    = bus.cfg_y1;
        y2_d[i]    = bus.cfg_y2;
        state_d[i] = ST_IDLE;
        cnt_d[i]   = 4'd0;
`ifdef TOUCH_REPEAT_EN
        rpt_d[i]   = '0;
`endif
      end else if (bus.smp_valid) begin
        case (state_q[i])
          ST_IDLE: begin
            if (inside_s[i]) begin
              if (sat_inc(cnt_q[i]) >= DEB_CNT) begin
                state_d[i] = ST_PRESSED;
                cnt_d[i]   = 4'd0;
                press_d[i] = 1'b1;
`ifdef TOUCH_REPEAT_EN
                rpt_d[i]   = '0;
`endif
              end else begin
                cnt_d[i] = sat_inc(cnt_q[i]);
              end
            end else begin
              cnt_d[i] = 4'd0;
            end
          end
          ST_PRESSED: begin
            if (!inside_s[i]) begin
              if (sat_inc(cnt_q[i]) >= DEB_CNT) begin
                state_d[i]   = ST_IDLE;
                cnt_d[i]     = 4'd0;
                release_d[i] = 1'b1;
              end else begin
                cnt_d[i] = sat_inc(cnt_q[i]);
              end
            end else begin
              cnt_d[i] = 4'd0;
            end
`ifdef TOUCH_REPEAT_EN
            // Every sample spent held counts, inside or not; a releasing
            // sample does not
            if (state_d[i] == ST_PRESSED) begin
              if ((rpt_q[i] + RW'(1)) == RPT_CNT) begin
                rpt_d[i]    = '0;
                repeat_d[i] = 1'b1;
              end else begin
                rpt_d[i] = rpt_q[i] + RW'(1);
              end
            end else begin
              rpt_d[i] = '0;
            end
`endif
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = 4'd0;
          end
        endcase
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // Summary outputs derived from next state so they align with the pulses
  always_comb begin
    any_d = |state_d;
    act_d = 3'd0;
    for (int i = NZONES - 1; i >= 0; i--) begin
      act_d = state_d[i] ? 3'(i) : act_d;
    end
  end

  // State, bounds and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NZONES; i++) begin
        x1_q[i] <= '1;
        x2_q[i] <= '0;
        y1_q[i] <= '1;
        y2_q[i] <= '0;
      end
      x1_q[0]   <= XW'(180);
      x2_q[0]   <= XW'(330);
      y1_q[0]   <= YW'(10);
      y2_q[0]   <= YW'(110);
      state_q   <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      act_q     <= 3'd0;
`ifdef TOUCH_REPEAT_EN
      rpt_q     <= '0;
      repeat_q  <= '0;
`endif
    end else begin
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
      act_q     <= act_d;
`ifdef TOUCH_REPEAT_EN
      rpt_q     <= rpt_d;
      repeat_q  <= repeat_d;
`endif
    end
  end

  assign bus.zone_hit  = state_q;
  assign bus.any_hit   = any_q;
  assign bus.act_zone  = act_q;
  assign bus.press_p   = press_q;
  assign bus.release_p = release_q;
`ifdef TOUCH_REPEAT_EN
  assign bus.repeat_p  = repeat_q;
`else
  assign bus.repeat_p  = '0;
`endif

endmodule

// File: tb/tb_touch_zone_decoder.sv
// -----------------------------------------------------------------------------
// tb_touch_zone_decoder
// Directed scenarios for the touch zone decoder followed by a randomized run
// checked cycle by cycle against a behavioural model of the zone rules.
// -----------------------------------------------------------------------------
module tb_touch_zone_decoder;
  localparam int NZ  = 4;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int DEB = 3;
  localparam int RPT = 32;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  touch_zone_if #(.NZONES(NZ), .XW(XW), .YW(YW)) bus ();

  touch_zone_decoder #(.NZONES(NZ), .XW(XW), .YW(YW), .DEB(DEB), .RPT(RPT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int bx1[NZ], bx2[NZ], by1[NZ], by2[NZ];
  bit m_pressed[NZ];
  int m_run[NZ];   // consecutive samples arguing for a state change
  int m_held[NZ];  // samples spent pressed since the press
  logic [NZ-1:0] e_hit, e_press, e_rel, e_rep;
  logic          e_any;
  logic [2:0]    e_act;

  function automatic bit m_inside(int i, int x, int y);
    if (bx1[i] > bx2[i] || by1[i] > by2[i]) return 1'b0;
    return (x >= bx1[i]) && (x <= bx2[i]) && (y >= by1[i]) && (y <= by2[i]);
  endfunction

  function automatic void model_step();
    e_press = '0;
    e_rel   = '0;
    e_rep   = '0;
    for (int i = 0; i < NZ; i++) begin
      bit ins;
      bit agrees;
      if (reset) begin
        bx1[i] = (1 << XW) - 1; bx2[i] = 0;
        by1[i] = (1 << YW) - 1; by2[i] = 0;
        if (i == 0) begin
          bx1[i] = 180; bx2[i] = 330; by1[i] = 10; by2[i] = 110;
        end
        m_pressed[i] = 1'b0; m_run[i] = 0; m_held[i] = 0;
      end else if (bus.cfg_we && (int'(bus.cfg_idx) == i)) begin
        bx1[i] = int'(bus.cfg_x1); bx2[i] = int'(bus.cfg_x2);
        by1[i] = int'(bus.cfg_y1); by2[i] = int'(bus.cfg_y2);
        m_pressed[i] = 1'b0; m_run[i] = 0; m_held[i] = 0;
      end else if (bus.smp_valid) begin
        ins    = m_inside(i, int'(bus.tor_x), int'(bus.tor_y));
        agrees = m_pressed[i] ? !ins : ins;
        m_run[i] = agrees ? m_run[i] + 1 : 0;
        if (m_run[i] == DEB) begin
          m_run[i]     = 0;
          m_pressed[i] = !m_pressed[i];
          if (m_pressed[i]) begin
            e_press[i] = 1'b1;
            m_held[i]  = 0;
          end else begin
            e_rel[i] = 1'b1;
          end
        end else if (m_pressed[i]) begin
          m_held[i]++;
`ifdef TOUCH_REPEAT_EN
          if (m_held[i] % RPT == 0) e_rep[i] = 1'b1;
`endif
        end
      end
    end
    e_act = 3'd0;
    for (int i = 0; i < NZ; i++) e_hit[i] = m_pressed[i];
    for (int i = NZ - 1; i >= 0; i--) if (m_pressed[i]) e_act = 3'(i);
    e_any = |e_hit;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic samp(int x, int y);
    bus.smp_valid = 1'b1;
    bus.tor_x     = XW'(x);
    bus.tor_y     = YW'(y);
    tick();
    bus.smp_valid = 1'b0;
  endtask

  task automatic cfg(int idx, int x1, int x2, int y1, int y2);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = 3'(idx);
    bus.cfg_x1  = XW'(x1);
    bus.cfg_x2  = XW'(x2);
    bus.cfg_y1  = YW'(y1);
    bus.cfg_y2  = YW'(y2);
    tick();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.zone_hit !== 4'b0000) begin n_err++; $display("FAIL reset_hit got=%b want=0000", bus.zone_hit); end
    n_vec++; if (bus.any_hit !== 1'b0) begin n_err++; $display("FAIL reset_any got=%b want=0", bus.any_hit); end
    n_vec++; if (bus.act_zone !== 3'd0) begin n_err++; $display("FAIL reset_act got=%0d want=0", bus.act_zone); end
    n_vec++; if ((bus.press_p | bus.release_p | bus.repeat_p) !== 4'b0000) begin
      n_err++; $display("FAIL reset_pulses got=%b/%b/%b want=0", bus.press_p, bus.release_p, bus.repeat_p);
    end
  endtask

  task automatic test_press();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      samp(200, 50);
      n_vec++;
      if (bus.press_p !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        n_err++; $display("FAIL press_pulse sample=%0d got=%b", k, bus.press_p);
      end
    end
    n_vec++; if (bus.zone_hit !== 4'b0001) begin n_err++; $display("FAIL press_hit got=%b want=0001", bus.zone_hit); end
    n_vec++; if (bus.act_zone !== 3'd0 || bus.any_hit !== 1'b1) begin
      n_err++; $display("FAIL press_act got=%0d/%b want=0/1", bus.act_zone, bus.any_hit);
    end
    tick();
    n_vec++; if (bus.press_p !== 4'b0000) begin n_err++; $display("FAIL press_width got=%b want=0000", bus.press_p); end
  endtask

  task automatic test_boundary();
    do_reset();
    samp(180, 10); samp(330, 110); samp(179, 50);
    samp(180, 10); samp(330, 110);
    n_vec++; if (bus.zone_hit !== 4'b0000) begin n_err++; $display("FAIL bnd_outside_clears got=%b want=0000", bus.zone_hit); end
    samp(330, 10);
    n_vec++; if (bus.press_p !== 4'b0001) begin n_err++; $display("FAIL bnd_corner_press got=%b want=0001", bus.press_p); end
    samp(179, 50); samp(331, 50);
    n_vec++; if (bus.release_p !== 4'b0000 || bus.zone_hit !== 4'b0001) begin
      n_err++; $display("FAIL bnd_early_release got=%b/%b want=0000/0001", bus.release_p, bus.zone_hit);
    end
    samp(200, 111);
    n_vec++; if (bus.release_p !== 4'b0001 || bus.zone_hit !== 4'b0000) begin
      n_err++; $display("FAIL bnd_y111_release got=%b/%b want=0001/0000", bus.release_p, bus.zone_hit);
    end
  endtask

  task automatic test_release();
    do_reset();
    repeat (3) samp(200, 50);
    samp(200, 50); samp(400, 50); samp(200, 50);
    for (int k = 1; k <= 3; k++) begin
      samp(400, 50);
      n_vec++;
      if (bus.release_p !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        n_err++; $display("FAIL release_pulse out_sample=%0d got=%b", k, bus.release_p);
      end
    end
    tick();
    n_vec++; if (bus.release_p !== 4'b0000 || bus.zone_hit !== 4'b0000) begin
      n_err++; $display("FAIL release_after got=%b/%b want=0000/0000", bus.release_p, bus.zone_hit);
    end
  endtask

  task automatic test_cfg();
    do_reset();
    cfg(1, 250, 400, 50, 150);
    repeat (3) samp(300, 100);
    n_vec++; if (bus.press_p !== 4'b0011 || bus.zone_hit !== 4'b0011) begin
      n_err++; $display("FAIL cfg_overlap got=%b/%b want=0011/0011", bus.press_p, bus.zone_hit);
    end
    n_vec++; if (bus.act_zone !== 3'd0) begin n_err++; $display("FAIL cfg_act got=%0d want=0", bus.act_zone); end
    cfg(0, 180, 330, 10, 110);
    n_vec++; if (bus.zone_hit !== 4'b0010 || bus.release_p !== 4'b0000) begin
      n_err++; $display("FAIL cfg_silent got=%b/%b want=0010/0000", bus.zone_hit, bus.release_p);
    end
    n_vec++; if (bus.act_zone !== 3'd1) begin n_err++; $display("FAIL cfg_act1 got=%0d want=1", bus.act_zone); end
  endtask

  task automatic test_repeat();
    int np = 0;
    int nr = 0;
    int want_rep;
`ifdef TOUCH_REPEAT_EN
    want_rep = 2;
`else
    want_rep = 0;
`endif
    do_reset();
    repeat (70) begin
      samp(200, 50);
      np += $countones(bus.press_p);
      nr += $countones(bus.repeat_p);
    end
    tick();
    nr += $countones(bus.repeat_p);
    n_vec++; if (np !== 1) begin n_err++; $display("FAIL repeat_press got=%0d want=1", np); end
    n_vec++; if (nr !== want_rep) begin n_err++; $display("FAIL repeat_count got=%0d want=%0d", nr, want_rep); end
  endtask

  task automatic test_reset_mid_press();
    do_reset();
    cfg(1, 250, 400, 50, 150);
    repeat (3) samp(200, 50);
    reset         = 1'b1;
    bus.smp_valid = 1'b1;
    bus.tor_x     = XW'(400);
    bus.tor_y     = YW'(50);
    tick();
    reset         = 1'b0;
    bus.smp_valid = 1'b0;
    n_vec++; if (bus.zone_hit !== 4'b0000 || bus.any_hit !== 1'b0 || bus.act_zone !== 3'd0) begin
      n_err++; $display("FAIL rstmid_state got=%b/%b/%0d want=0", bus.zone_hit, bus.any_hit, bus.act_zone);
    end
    n_vec++; if ((bus.release_p | bus.press_p) !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_pulse got=%b/%b want=0000", bus.release_p, bus.press_p);
    end
    repeat (3) samp(350, 100);
    n_vec++; if (bus.zone_hit !== 4'b0000) begin n_err++; $display("FAIL rstmid_zone1_disabled got=%b want=0000", bus.zone_hit); end
    repeat (3) samp(200, 50);
    n_vec++; if (bus.press_p !== 4'b0001) begin n_err++; $display("FAIL rstmid_zone0_default got=%b want=0001", bus.press_p); end
  endtask

  task automatic test_random();
    int px = 100;
    int py = 50;
    int a, b, c, d;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0) begin
        px = $urandom_range(0, 255);
        py = $urandom_range(0, 127);
      end
      bus.smp_valid = ($urandom_range(0, 1) == 1);
      bus.tor_x     = XW'(px);
      bus.tor_y     = YW'(py);
      bus.cfg_we    = ($urandom_range(0, 29) == 0);
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      c = $urandom_range(0, 127); d = $urandom_range(0, 127);
      if ($urandom_range(0, 4) != 0) begin
        if (a > b) begin int t = a; a = b; b = t; end
        if (c > d) begin int t = c; c = d; d = t; end
      end
      bus.cfg_idx = 3'($urandom_range(0, 7));
      bus.cfg_x1  = XW'(a);
      bus.cfg_x2  = XW'(b);
      bus.cfg_y1  = YW'(c);
      bus.cfg_y2  = YW'(d);
      tick();
      n_vec++; if (bus.zone_hit !== e_hit) begin n_err++; $display("FAIL rnd_hit cyc=%0d got=%b want=%b", n, bus.zone_hit, e_hit); end
      n_vec++; if (bus.any_hit !== e_any) begin n_err++; $display("FAIL rnd_any cyc=%0d got=%b want=%b", n, bus.any_hit, e_any); end
      n_vec++; if (bus.act_zone !== e_act) begin n_err++; $display("FAIL rnd_act cyc=%0d got=%0d want=%0d", n, bus.act_zone, e_act); end
      n_vec++; if (bus.press_p !== e_press) begin n_err++; $display("FAIL rnd_press cyc=%0d got=%b want=%b", n, bus.press_p, e_press); end
      n_vec++; if (bus.release_p !== e_rel) begin n_err++; $display("FAIL rnd_release cyc=%0d got=%b want=%b", n, bus.release_p, e_rel); end
      n_vec++; if (bus.repeat_p !== e_rep) begin n_err++; $display("FAIL rnd_repeat cyc=%0d got=%b want=%b", n, bus.repeat_p, e_rep); end
    end
    reset         = 1'b0;
    bus.smp_valid = 1'b0;
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.smp_valid = 1'b0;
    bus.tor_x     = '0;
    bus.tor_y     = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = 3'd0;
    bus.cfg_x1    = '0;
    bus.cfg_x2    = '0;
    bus.cfg_y1    = '0;
    bus.cfg_y2    = '0;
    test_reset();
    test_press();
    test_boundary();
    test_release();
    test_cfg();
    test_repeat();
    test_reset_mid_press();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/touch_zone_decoder.md
TOUCH_ZONE_DECODER -- requirements
Module: touch_zone_decoder

Interface
REQ-001 Parameter NZONES, default 4: number of rectangular touch zones, legal range 1..8.
REQ-002 Parameter XW, default 10: touch X coordinate width.
REQ-003 Parameter YW, default 9: touch Y coordinate width.
REQ-004 Parameter DEB, default 3: consecutive qualifying samples needed to change a zone's state, legal range 1..15.
REQ-005 Parameter RPT, default 32: samples between repeat pulses while a zone is held.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 smp_valid  in  1  one-cycle strobe marking a valid touch sample.
REQ-009 tor_x  in  XW  touch X; sampled only when smp_valid=1.
REQ-010 tor_y  in  YW  touch Y; sampled only when smp_valid=1.
REQ-011 cfg_we  in  1  zone-rectangle write strobe.
REQ-012 cfg_idx  in  3  zone index to write; ignored when >= NZONES.
REQ-013 cfg_x1 / cfg_x2  in  XW each  inclusive X bounds.
REQ-014 cfg_y1 / cfg_y2  in  YW each  inclusive Y bounds.
REQ-015 zone_hit  out  NZONES  registered, debounced pressed state per zone.
REQ-016 any_hit  out  1  OR of zone_hit, registered.
REQ-017 act_zone  out  3  lowest index with zone_hit=1; 0 when none.
REQ-018 press_p / release_p / repeat_p  out  NZONES each  one-cycle event pulses per zone.

Function
REQ-019 Per zone, raw inside = (x1<=tor_x<=x2) && (y1<=tor_y<=y2), all compares unsigned and inclusive.
REQ-020 A zone with x1>x2 or y1>y2 is disabled; its raw inside is always 0.
REQ-021 Each zone has a 2-state FSM, IDLE/PRESSED, plus a 4-bit saturating debounce counter.
REQ-022 IDLE: on each smp_valid with inside=1, counter increments; with inside=0, counter clears.
REQ-023 IDLE -> PRESSED on the sample that makes the counter reach DEB; counter clears; press_p pulses in the next cycle.
REQ-024 PRESSED: on each smp_valid with inside=0, counter increments; with inside=1, counter clears.
REQ-025 PRESSED -> IDLE when the counter reaches DEB; counter clears; release_p pulses in the next cycle.
REQ-026 Cycles with smp_valid=0 freeze all counters and states; no sample timeout exists.
REQ-027 zone_hit, any_hit and act_zone update one cycle after the qualifying smp_valid, aligned with press_p/release_p.
REQ-028 Zones are evaluated independently; overlapping zones may be pressed simultaneously.
REQ-029 A cfg_we write to zone i updates its bounds in the next cycle, forces zone i to IDLE, and clears its counters without emitting release_p.
REQ-030 If cfg_we and smp_valid coincide for the same zone, the write wins and the sample is discarded for that zone only.
REQ-031 Event pulses are exactly one cycle wide; at most one of press_p[i]/release_p[i] is asserted per cycle.

Reset
REQ-032 Reset returns all zones to IDLE, clears all counters, and drives every output to 0.
REQ-033 Reset loads zone 0 as X 180..330, Y 10..110; all other zones load x1=all-ones, x2=0 (disabled).
REQ-034 Reset asserted mid-press clears state with no release_p pulse.

Configuration
REQ-035 Macro TOUCH_REPEAT_EN: when defined, each PRESSED zone has a repeat counter; after every RPT further smp_valid samples (inside or not) spent in PRESSED, repeat_p[i] pulses for one cycle; the counter clears on entering PRESSED.
REQ-036 Without TOUCH_REPEAT_EN, no repeat counters are built and repeat_p is tied to 0.

Verification
REQ-037 After reset, DEB=3, send 3 valid samples at (200,50) -> press_p[0] pulses once 1 cycle after sample 3; zone_hit=0001, act_zone=0.
REQ-038 Boundary test: samples at (180,10) and (330,110) are inside; samples at (179,50) and (331,50) are outside; a sample at (200,111) counts as an outside sample.
REQ-039 Pressed zone 0: inside, outside, inside, then 3 outside samples -> release_p[0] after the 3rd outside sample only.
REQ-040 Program zone 1 = 250..400, 50..150 and press at (300,100) -> zone_hit=0011, act_zone=0; cfg write to zone 0 -> zone_hit=0010 with no release_p[0].
REQ-041 With TOUCH_REPEAT_EN and RPT=32, hold (200,50) for 70 samples -> press_p[0] once, then repeat_p[0] exactly twice.
REQ-042 Assert reset while zone 0 is pressed -> all outputs 0 next cycle, no release_p, and zone 0 bounds restored to default.
